exec_alu: RTL and testbench
===========================

EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 Parameter DATA_W, default 32, datapath and result width; legal range 24..64.
REQ-002 Parameter STACK_STEP, default 1, stack-pointer adjust applied by push/pop/ret.
REQ-003 Parameter CALL_LEN, default 6, constant produced by call (0xe8).
REQ-004 Parameter MOVI_LEN, default 3, instruction-length constant produced by mov-immediate second phase.
REQ-005 clock  in  1  single rising-edge clock; replaces the former clock_4/clock_6 phase clocks.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request to execute ope; honoured only when busy=0.
REQ-008 ope  in  32  instruction word; opcode in ope[31:24], immediate bytes in ope[23:0].
REQ-009 registor_in  in  DATA_W  register-file read operand, sampled live in each phase.
REQ-010 immidiate_data  in  DATA_W  second operand for add/sub.
REQ-011 busy  out  1  high while an instruction is in flight.
REQ-012 result_valid  out  1  one-cycle pulse per produced result.
REQ-013 result_phase  out  1  0 = first result of an instruction, 1 = second.
REQ-014 alu_result_bus  out  DATA_W  result value, held between pulses.
REQ-015 carry_flag, zero_flag, illegal_op  out  1 each  status, updated with every result_valid pulse.

Function
REQ-016 FSM states IDLE, PH0, PH1; IDLE --start--> PH0; PH0 --two-phase op--> PH1, else --> IDLE; PH1 --> IDLE unconditionally.
REQ-017 At the edge where start=1 in IDLE, ope is latched; later changes to ope have no effect until the next accepted start.
REQ-018 busy=1 exactly in PH0 and PH1; start while busy=1 is ignored, not queued.
REQ-019 Latency: start accepted at edge k -> phase-0 result registered at edge k+1; phase-1 result (if any) at edge k+2; next start accepted no earlier than the edge at which state returns to IDLE.
REQ-020 0x55 push: PH0 = registor_in + STACK_STEP; PH1 = registor_in.
REQ-021 0x89 mov: single phase, result = registor_in.
REQ-022 0xb8 mov-imm: PH0 = zero-extended {ope[7:0], ope[15:8], ope[23:16]}; PH1 = MOVI_LEN.
REQ-023 0x5d pop: PH0 = registor_in; PH1 = registor_in - STACK_STEP.
REQ-024 0xc3 ret: PH0 and PH1 = registor_in - STACK_STEP.
REQ-025 0xe8 call: PH0 and PH1 = CALL_LEN.
REQ-026 New 0x01 add: single phase, result = registor_in + immidiate_data; carry_flag = carry-out of bit DATA_W-1.
REQ-027 New 0x29 sub: single phase, result = registor_in - immidiate_data; carry_flag = borrow.
REQ-028 All arithmetic is modulo 2^DATA_W: 0 - STACK_STEP wraps to all-ones minus STACK_STEP-1; all-ones + 1 = 0 with carry_flag=1 for add.
REQ-029 carry_flag is 0 for every opcode except add/sub; zero_flag = (result == 0) on every pulse.
REQ-030 Unknown opcode: single phase, result_valid=1, illegal_op=1, alu_result_bus unchanged, carry_flag=0; illegal_op=0 on every legal pulse.

Reset
REQ-031 reset_n=0 forces, asynchronously: state IDLE, busy 0, result_valid 0, result_phase 0, alu_result_bus 0, all flags 0, latched opcode 0x00.
REQ-032 Reset asserted mid-instruction aborts it; no further pulse for that instruction after reset release.
REQ-033 First start is accepted at the first rising edge with reset_n=1.

Structure
REQ-034 Opcode constants (OP_PUSH_EBP 0x55, OP_MOV 0x89, OP_MOVI 0xb8, OP_POP_EBP 0x5d, OP_RET 0xc3, OP_CALL 0xe8, OP_ADD 0x01, OP_SUB 0x29) and the FSM state encoding reside in shared package cpu_pkg.
REQ-035 One sub-module, alu_core: purely combinational opcode + phase + operands -> result, carry, illegal; exec_alu holds FSM and output registers.

Verification
REQ-036 push, registor_in=0x100 -> pulses 0x101 (phase 0) then 0x100 (phase 1) on edges k+1, k+2; busy high for 2 cycles.
REQ-037 ope=0xb8123456 -> phase 0 result 0x00563412, phase 1 result 0x3.
REQ-038 add, registor_in=0xFFFFFFFF, immidiate_data=1 -> single pulse, result 0, zero_flag=1, carry_flag=1; sub 0 - 1 -> 0xFFFFFFFF, carry_flag=1.
REQ-039 start held high during ret -> second start accepted only when state is IDLE; exactly 2 pulses per ret, none lost or duplicated.
REQ-040 reset_n low between PH0 and PH1 of pop -> all outputs 0 immediately, no phase-1 pulse after release.
REQ-041 opcode 0xff after a mov that produced 0x55 -> pulse with illegal_op=1, alu_result_bus stays 0x55; DATA_W=48 rerun of REQ-036/038 wraps at 2^48.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification for exec_alu.
package cpu_pkg;

    localparam int unsigned OPE_W = 32;
    localparam int unsigned OPC_W = 8;
    localparam int unsigned IMM_W = 24;

    localparam logic [OPC_W-1:0] OP_PUSH_EBP = 8'h55;
    localparam logic [OPC_W-1:0] OP_MOV      = 8'h89;
    localparam logic [OPC_W-1:0] OP_MOVI     = 8'hb8;
    localparam logic [OPC_W-1:0] OP_POP_EBP  = 8'h5d;
    localparam logic [OPC_W-1:0] OP_RET      = 8'hc3;
    localparam logic [OPC_W-1:0] OP_CALL     = 8'he8;
    localparam logic [OPC_W-1:0] OP_ADD      = 8'h01;
    localparam logic [OPC_W-1:0] OP_SUB      = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH0  = 2'd1,
        ST_PH1  = 2'd2
    } state_t;

    // Opcodes that produce a second result in PH1.
    function automatic logic is_two_phase(input logic [OPC_W-1:0] op);
        return (op == OP_PUSH_EBP) || (op == OP_MOVI) || (op == OP_POP_EBP) ||
               (op == OP_RET)      || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational result generator: opcode + phase + operands -> result, carry, illegal.
// Ports:
//   i_opcode  latched opcode byte
//   i_phase   0 = first result, 1 = second result
//   i_imm24   latched immediate bytes (ope[23:0])
//   i_reg     register-file operand (live)
//   i_imm     second operand for add/sub
//   o_result  result value (don't-care when o_illegal)
//   o_carry   carry-out (add) / borrow (sub), 0 otherwise
//   o_illegal unknown opcode
module alu_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STACK_STEP = 1,
    parameter int unsigned CALL_LEN   = 6,
    parameter int unsigned MOVI_LEN   = 3
) (
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic              i_phase,
    input  logic [IMM_W-1:0]  i_imm24,
    input  logic [DATA_W-1:0] i_reg,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_illegal
);

    localparam logic [DATA_W-1:0] STEP  = DATA_W'(STACK_STEP);
    localparam logic [DATA_W-1:0] CALLV = DATA_W'(CALL_LEN);
    localparam logic [DATA_W-1:0] MOVIV = DATA_W'(MOVI_LEN);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [IMM_W-1:0]  w_swapped;

    // Extra top bit carries the carry-out / borrow.
    assign w_sum     = {1'b0, i_reg} + {1'b0, i_imm};
    assign w_diff    = {1'b0, i_reg} - {1'b0, i_imm};
    // Little-endian immediate bytes reassembled into a value.
    assign w_swapped = {i_imm24[7:0], i_imm24[15:8], i_imm24[23:16]};

    always_comb begin
        o_result  = '0;
        o_carry   = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_PUSH_EBP: o_result = i_phase ? i_reg : (i_reg + STEP);
            OP_MOV:      o_result = i_reg;
            OP_MOVI:     o_result = i_phase ? MOVIV : DATA_W'(w_swapped);
            OP_POP_EBP:  o_result = i_phase ? (i_reg - STEP) : i_reg;
            OP_RET:      o_result = i_reg - STEP;
            OP_CALL:     o_result = CALLV;
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
            end
            default:     o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_alu.sv
// Execution unit: accepts an instruction word, runs it through one or two
// result phases and registers each result with status flags.
// Ports:
//   clock, reset_n         clock / async active-low reset
//   start, ope             instruction request and word (opcode in [31:24])
//   registor_in            register operand, sampled live each phase
//   immidiate_data         second operand for add/sub
//   busy                   instruction in flight (PH0/PH1)
//   result_valid           one-cycle pulse per result
//   result_phase           0 = first result, 1 = second
//   alu_result_bus         last result, held between pulses
//   carry_flag, zero_flag, illegal_op   status, updated with each pulse
module exec_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STACK_STEP = 1,
    parameter int unsigned CALL_LEN   = 6,
    parameter int unsigned MOVI_LEN   = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [OPE_W-1:0]  ope,
    input  logic [DATA_W-1:0] registor_in,
    input  logic [DATA_W-1:0] immidiate_data,
    output logic              busy,
    output logic              result_valid,
    output logic              result_phase,
    output logic [DATA_W-1:0] alu_result_bus,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              illegal_op
);

    if (DATA_W < 24 || DATA_W > 64) begin : g_bad_width
        $error("exec_alu: DATA_W must be within 24..64");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [OPE_W-1:0]  r_ope;
    logic              r_busy;
    logic              r_valid;
    logic              r_phase;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic              r_zero;
    logic              r_illegal;

    logic              w_accept;
    logic              w_pulse;
    logic              w_phase;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_illegal;

    assign w_phase = (r_state == ST_PH1);

    alu_core #(
        .DATA_W     (DATA_W),
        .STACK_STEP (STACK_STEP),
        .CALL_LEN   (CALL_LEN),
        .MOVI_LEN   (MOVI_LEN)
    ) u_alu_core (
        .i_opcode  (r_ope[OPE_W-1 -: OPC_W]),
        .i_phase   (w_phase),
        .i_imm24   (r_ope[IMM_W-1:0]),
        .i_reg     (registor_in),
        .i_imm     (immidiate_data),
        .o_result  (w_result),
        .o_carry   (w_carry),
        .o_illegal (w_illegal)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pulse     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PH0;
                end
            end
            ST_PH0: begin
                w_pulse     = 1'b1;
                w_state_nxt = is_two_phase(r_ope[OPE_W-1 -: OPC_W]) ? ST_PH1 : ST_IDLE;
            end
            ST_PH1: begin
                w_pulse     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, instruction latch and busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ope   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_ope <= ope;
            end
        end
    end

    // Result and status registers; an illegal opcode keeps the previous result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_phase   <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= w_pulse;
            if (w_pulse) begin
                r_phase   <= w_phase;
                r_carry   <= w_carry;
                r_illegal <= w_illegal;
                if (w_illegal) begin
                    r_zero <= (r_result == '0);
                end else begin
                    r_result <= w_result;
                    r_zero   <= (w_result == '0);
                end
            end
        end
    end

    assign busy           = r_busy;
    assign result_valid   = r_valid;
    assign result_phase   = r_phase;
    assign alu_result_bus = r_result;
    assign carry_flag     = r_carry;
    assign zero_flag      = r_zero;
    assign illegal_op     = r_illegal;

endmodule

// File: tb/tb_exec_alu.sv
// Directed self-checking bench for exec_alu (DATA_W=32 and DATA_W=48 instances).
module tb_exec_alu;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] ope;
    logic [31:0] reg32, imm32;
    logic [47:0] reg48, imm48;

    logic        busy, valid, phase, carry, zero, illegal;
    logic [31:0] bus;
    logic        busy48, valid48, phase48, carry48, zero48, illegal48;
    logic [47:0] bus48;

    int n_chk  = 0;
    int n_pass = 0;

    logic [47:0] s48_0, s48_1;
    logic        c48_0, z48_0;

    exec_alu u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .ope            (ope),
        .registor_in    (reg32),
        .immidiate_data (imm32),
        .busy           (busy),
        .result_valid   (valid),
        .result_phase   (phase),
        .alu_result_bus (bus),
        .carry_flag     (carry),
        .zero_flag      (zero),
        .illegal_op     (illegal)
    );

    exec_alu #(.DATA_W(48)) u_dut48 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .ope            (ope),
        .registor_in    (reg48),
        .immidiate_data (imm48),
        .busy           (busy48),
        .result_valid   (valid48),
        .result_phase   (phase48),
        .alu_result_bus (bus48),
        .carry_flag     (carry48),
        .zero_flag      (zero48),
        .illegal_op     (illegal48)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one instruction and check every pulse of the 32-bit instance.
    task automatic run_op(input string tag, input logic [31:0] op, input bit two,
                          input logic [31:0] e0, input logic [31:0] e1, input bit ec);
        @(negedge clock);
        ope   = op;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ope   = 32'hdead_beef;
        check({tag, ".busy_acc"}, 64'(busy), 64'd1);
        @(posedge clock); #1;
        check({tag, ".v0"},     64'(valid),   64'd1);
        check({tag, ".ph0"},    64'(phase),   64'd0);
        check({tag, ".r0"},     64'(bus),     64'(e0));
        check({tag, ".c0"},     64'(carry),   64'(ec));
        check({tag, ".z0"},     64'(zero),    64'(e0 == 32'd0));
        check({tag, ".ill0"},   64'(illegal), 64'd0);
        s48_0 = bus48; c48_0 = carry48; z48_0 = zero48;
        if (two) begin
            check({tag, ".busy_ph1"}, 64'(busy), 64'd1);
            @(posedge clock); #1;
            check({tag, ".v1"},  64'(valid), 64'd1);
            check({tag, ".ph1"}, 64'(phase), 64'd1);
            check({tag, ".r1"},  64'(bus),   64'(e1));
            check({tag, ".c1"},  64'(carry), 64'd0);
            s48_1 = bus48;
        end
        check({tag, ".busy_end"}, 64'(busy), 64'd0);
        @(posedge clock); #1;
        check({tag, ".v_end"}, 64'(valid), 64'd0);
    endtask

    initial begin
        int pulses;
        reset_n = 1'b0;
        start   = 1'b0;
        ope     = 32'h0;
        reg32 = 32'h0; imm32 = 32'h0;
        reg48 = 48'h0; imm48 = 48'h0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst.busy",  64'(busy),    64'd0);
        check("rst.valid", 64'(valid),   64'd0);
        check("rst.bus",   64'(bus),     64'd0);
        check("rst.flags", 64'({carry, zero, illegal, phase}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // push
        reg32 = 32'h100; reg48 = 48'h100;
        run_op("push", 32'h5500_0000, 1'b1, 32'h101, 32'h100, 1'b0);
        check("push48.r0", 64'(s48_0), 64'h101);
        check("push48.r1", 64'(s48_1), 64'h100);

        // mov-immediate byte swap
        run_op("movi", 32'hb812_3456, 1'b1, 32'h0056_3412, 32'h3, 1'b0);

        // add wrap
        reg32 = 32'hffff_ffff; imm32 = 32'h1;
        reg48 = 48'hffff_ffff_ffff; imm48 = 48'h1;
        run_op("add_wrap", 32'h0100_0000, 1'b0, 32'h0, 32'h0, 1'b1);
        check("add48.r",  64'(s48_0), 64'h0);
        check("add48.c",  64'(c48_0), 64'd1);
        check("add48.z",  64'(z48_0), 64'd1);

        // add no carry
        reg32 = 32'h1234; imm32 = 32'h10;
        run_op("add", 32'h0100_0000, 1'b0, 32'h1244, 32'h0, 1'b0);

        // sub borrow
        reg32 = 32'h0; imm32 = 32'h1;
        reg48 = 48'h0; imm48 = 48'h1;
        run_op("sub_borrow", 32'h2900_0000, 1'b0, 32'hffff_ffff, 32'h0, 1'b1);
        check("sub48.r", 64'(s48_0), 64'hffff_ffff_ffff);

        // mov then illegal
        reg32 = 32'h55;
        run_op("mov", 32'h8900_0000, 1'b0, 32'h55, 32'h0, 1'b0);
        @(negedge clock);
        ope = 32'hff00_0000; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        check("ill.valid", 64'(valid),   64'd1);
        check("ill.flag",  64'(illegal), 64'd1);
        check("ill.bus",   64'(bus),     64'h55);
        check("ill.carry", 64'(carry),   64'd0);
        check("ill.busy",  64'(busy),    64'd0);

        // call
        run_op("call", 32'he800_0000, 1'b1, 32'h6, 32'h6, 1'b0);

        // pop
        reg32 = 32'h200;
        run_op("pop", 32'h5d00_0000, 1'b1, 32'h200, 32'h1ff, 1'b0);

        // ret with start held: two acceptances, exactly four pulses
        reg32 = 32'h10;
        pulses = 0;
        @(negedge clock);
        ope = 32'hc300_0000; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (valid) begin
                pulses++;
                check("ret.r", 64'(bus), 64'hf);
            end
            if (i == 2) check("ret.busy_idle", 64'(busy), 64'd0);
            if (i == 3) begin
                check("ret.busy_reacc", 64'(busy), 64'd1);
                start = 1'b0;
            end
        end
        check("ret.pulses", 64'(pulses), 64'd4);

        // reset between PH0 and PH1 of pop
        reg32 = 32'h300;
        @(negedge clock);
        ope = 32'h5d00_0000; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        check("rpop.r0", 64'(bus), 64'h300);
        #2 reset_n = 1'b0;
        #1;
        check("rpop.busy",  64'(busy),  64'd0);
        check("rpop.valid", 64'(valid), 64'd0);
        check("rpop.bus",   64'(bus),   64'd0);
        check("rpop.flags", 64'({carry, zero, illegal, phase}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (valid) pulses++;
        end
        check("rpop.no_pulse", 64'(pulses), 64'd0);

        // first instruction after reset release
        reg32 = 32'h7;
        run_op("mov_post", 32'h8900_0000, 1'b0, 32'h7, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
